// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Two-requester round-robin front end for a shared WIDTH-bit adder that sits
//   outside this block. An accepted request is held in the operand register
//   (S1), which drives the adder. On the following edge the adder result is
//   captured into the result register (S2), which drives the response
//   interface. Total latency is two cycles. Throughput is one add per cycle
//   while the consumer keeps rsp_ready high.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (ready = grant)
//   reqN_a, reqN_b, reqN_cin operands and carry-in of requester N
//   add_a, add_b, add_cin    operands driven to the shared adder (from S1)
//   add_sum, add_cout        combinational result returned by the shared adder
//   rsp_valid / rsp_ready    response handshake (from S2)
//   rsp_id                   requester that owns the response
//   rsp_sum, rsp_cout        sum and carry-out of the response
module adder_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,

  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,

  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  input  logic             rsp_ready
);

  // S1: operand stage
  logic             r_s1_v;
  logic             r_s1_id;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;

  // S2: result stage
  logic             r_s2_v;
  logic             r_s2_id;
  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_cout;

  // Owner of the most recent transfer. It resets to 1 so requester 0 wins the first tie.
  logic             r_last_grant;

  logic             w_advance;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic             w_s2_load;

  always_comb begin
    w_advance = !r_s1_v || !r_s2_v || rsp_ready;
    // Grants are masked during reset. With S1/S2 cleared, w_advance is high,
    // so without the mask a valid request would be acknowledged while in reset.
    w_grant0  = !rst && w_advance && req0_valid && (!req1_valid ||  r_last_grant);
    w_grant1  = !rst && w_advance && req1_valid && (!req0_valid || !r_last_grant);
    w_grant   = w_grant0 || w_grant1;
    w_s2_load = r_s1_v && (!r_s2_v || rsp_ready);
  end

  // S1 and arbitration state. Whenever S1 is full, w_advance equals w_s2_load.
  // So on an advancing edge S1 either refills from the grant or empties into S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v       <= 1'b0;
      r_s1_id      <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_cin     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_advance) begin
      r_s1_v <= w_grant;
      if (w_grant) begin
        r_s1_id      <= w_grant1;
        r_s1_a       <= w_grant1 ? req1_a   : req0_a;
        r_s1_b       <= w_grant1 ? req1_b   : req0_b;
        r_s1_cin     <= w_grant1 ? req1_cin : req0_cin;
        r_last_grant <= w_grant1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v    <= 1'b0;
      r_s2_id   <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_cout <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v    <= 1'b1;
      r_s2_id   <= r_s1_id;
      r_s2_sum  <= add_sum;
      r_s2_cout <= add_cout;
    end else if (rsp_ready) begin
      r_s2_v <= 1'b0;
    end
  end

  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    add_a      = r_s1_a;
    add_b      = r_s1_b;
    add_cin    = r_s1_cin;
    rsp_valid  = r_s2_v;
    rsp_id     = r_s2_id;
    rsp_sum    = r_s2_sum;
    rsp_cout   = r_s2_cout;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_cin, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_cin, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_ready;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ready(rsp_ready)
  );

  // The shared adder that the block drives.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic grant_log[$];
  int   cur_run = 0;
  int   max_run = 0;
  logic last_id = 1'b1;

  logic         p_stall = 1'b0;
  logic         p_id, p_cout;
  logic [W-1:0] p_sum;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: plain (W+1)-bit arithmetic on the accepted operands.
  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = id;
    e.sum  = t[W-1:0];
    e.cout = t[W];
    return e;
  endfunction

  // Monitor/scoreboard. Samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_id = 1'b1;
      p_stall = 1'b0;
      cur_run = 0;
    end else begin
      chk1("ready_mutex", req0_ready && req1_ready, 1'b0);
      if (!req0_valid) chk1("ready0_without_valid", req0_ready, 1'b0);
      if (!req1_valid) chk1("ready1_without_valid", req1_ready, 1'b0);
      if (p_stall) begin
        chk1("stall_valid_hold", rsp_valid, 1'b1);
        chk1("stall_id_hold", rsp_id, p_id);
        chkw("stall_sum_hold", rsp_sum, p_sum);
        chk1("stall_cout_hold", rsp_cout, p_cout);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: got id=%0b sum=%0h expected no response", rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
          chk1("rsp_id", rsp_id, e.id);
          chkw("rsp_sum", rsp_sum, e.sum);
          chk1("rsp_cout", rsp_cout, e.cout);
        end
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        chk1("rr_winner_is_1", req1_ready, !last_id);
      if (req0_valid && req0_ready) begin
        sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
        grant_log.push_back(1'b0);
        last_id = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
        grant_log.push_back(1'b1);
        last_id = 1'b1;
      end
      p_stall = rsp_valid && !rsp_ready;
      p_id    = rsp_id;
      p_sum   = rsp_sum;
      p_cout  = rsp_cout;
    end
  end

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = '1;
      1:       v = '0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Call this just after a rising edge. It returns just after the edge on which the request transferred.
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bit got = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk1("issue_granted", got, 1'b1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        idle = 1'b1;
        break;
      end
    end
    chk1("drain_complete", idle, 1'b1);
  endtask

  logic         first_exp;
  logic [W-1:0] s_a, s_b;
  logic         s_cin;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chkw("rst_rsp_sum", rsp_sum, '0);
    chk1("rst_rsp_cout", rsp_cout, 1'b0);
    chkw("rst_add_a", add_a, '0);
    chkw("rst_add_b", add_b, '0);
    chk1("rst_add_cin", add_cin, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single add: grant in the same cycle, response two edges later
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 64'h5; req0_b = 64'hA; req0_cin = 1'b0;
    @(negedge clk);
    chk1("single_ready_same_cycle", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("single_no_rsp_after_1", rsp_valid, 1'b0);
    chkw("single_add_a", add_a, 64'h5);
    @(negedge clk);
    chk1("single_rsp_after_2", rsp_valid, 1'b1);
    chkw("single_sum", rsp_sum, 64'hF);
    wait_idle();

    // Tie: both requesters valid continuously, so grants alternate
    @(posedge clk); #1;
    grant_log.delete();
    first_exp = !last_id;
    req0_a = 64'hFF; req0_b = 64'h1; req0_cin = 1'b1;
    req1_a = '1;     req1_b = 64'h1; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chkw("tie_grant_count", W'(grant_log.size()), W'(6));
    if (grant_log.size() == 6) begin
      chk1("tie_first_grant", grant_log[0], first_exp);
      for (int i = 1; i < 6; i++) chk1("tie_alternate", grant_log[i], !grant_log[i-1]);
    end
    wait_idle();

    // Overflow on requester 1
    @(posedge clk); #1;
    issue(1'b1, '1, '1, 1'b1);
    wait_idle();

    // Backpressure with S1 and S2 both full
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1'b0, rand_op(), rand_op(), 1'b1);
    issue(1'b1, rand_op(), rand_op(), 1'b0);
    s_a = add_a; s_b = add_b; s_cin = add_cin;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("bp_req0_ready_low", req0_ready, 1'b0);
      chk1("bp_req1_ready_low", req1_ready, 1'b0);
      chkw("bp_add_a_stable", add_a, s_a);
      chkw("bp_add_b_stable", add_b, s_b);
      chk1("bp_add_cin_stable", add_cin, s_cin);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Back-to-back issues from requester 0
    @(posedge clk); #1;
    max_run = 0;
    for (int i = 0; i < 4; i++) issue(1'b0, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    wait_idle();
    chkw("b2b_rsp_run", W'(max_run), W'(4));

    // Reset while an add is in flight
    @(posedge clk); #1;
    issue(1'b0, 64'h1234567890ABCDEF, 64'hFEDCBA0987654321, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    req0_valid = 1'b1; req0_a = 64'h11; req0_b = 64'h22; req0_cin = 1'b1;
    req1_valid = 1'b1; req1_a = 64'h33; req1_b = 64'h44; req1_cin = 1'b0;
    #1;
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chkw("mid_rst_rsp_sum", rsp_sum, '0);
    chk1("mid_rst_rsp_id", rsp_id, 1'b0);
    chk1("mid_rst_rsp_cout", rsp_cout, 1'b0);
    chkw("mid_rst_add_a", add_a, '0);
    chkw("mid_rst_add_b", add_b, '0);
    chk1("mid_rst_add_cin", add_cin, 1'b0);
    chk1("mid_rst_req0_ready", req0_ready, 1'b0);
    chk1("mid_rst_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_req0_first", req0_ready, 1'b1);
    chk1("post_rst_req1_waits", req1_ready, 1'b0);
    chk1("post_rst_no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Random traffic with random consumer backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
